// File: rtl/syn_gpu_div_arb_if.sv
// Mulberry divider arbiter bus: client request/response side plus divider request/response side.
// The arbiter takes the master view; the environment (clients and divider) takes the slave view.
interface syn_gpu_div_arb_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 16,
  parameter int MID_W       = 4
);
  logic [NUM_CLIENTS-1:0]        cl_req_valid;
  logic [NUM_CLIENTS-1:0]        cl_req_rdy;
  logic [NUM_CLIENTS*DATA_W-1:0] cl_dividend;
  logic [NUM_CLIENTS*DATA_W-1:0] cl_divisor;
  logic [NUM_CLIENTS-1:0]        cl_rsp_valid;
  logic [DATA_W-1:0]             cl_rsp_quot;
  logic [DATA_W-1:0]             cl_rsp_rem;
  logic                          cl_rsp_err;
  logic [MID_W-1:0]              div_req_mid;
  logic [2*DATA_W-1:0]           div_req_data;
  logic                          div_busy;
  logic [MID_W-1:0]              div_rsp_mid;
  logic [2*DATA_W-1:0]           div_rsp_data;
  logic                          err_mid_mismatch;
  logic                          err_timeout;

  modport master (
    input  cl_req_valid, cl_dividend, cl_divisor, div_busy, div_rsp_mid, div_rsp_data,
    output cl_req_rdy, cl_rsp_valid, cl_rsp_quot, cl_rsp_rem, cl_rsp_err,
           div_req_mid, div_req_data, err_mid_mismatch, err_timeout
  );

  modport slave (
    output cl_req_valid, cl_dividend, cl_divisor, div_busy, div_rsp_mid, div_rsp_data,
    input  cl_req_rdy, cl_rsp_valid, cl_rsp_quot, cl_rsp_rem, cl_rsp_err,
           div_req_mid, div_req_data, err_mid_mismatch, err_timeout
  );
endinterface

// File: rtl/syn_gpu_div_arb.sv
// Round-robin sequencer sharing one mulberry divider among GPU agents, one division in flight,
// with divide-by-zero short-circuit and response timeout recovery.
module syn_gpu_div_arb #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 16,
  parameter int MID_W       = 4,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic              clk_ir,
  input  logic              rst_sync_l,
  syn_gpu_div_arb_if.master bus
);
  localparam int GW = $clog2(NUM_CLIENTS);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [MID_W-1:0] MID_IDLE = '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RSP} state_t;

  state_t            state, state_nx;
  logic [GW-1:0]     ptr, ptr_nx, grant, grant_nx;
  logic [DATA_W-1:0] dvd, dvd_nx, dvs, dvs_nx;
  logic [DATA_W-1:0] quot, quot_nx, rem, rem_nx;
  logic              err, err_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              mm, mm_nx, to, to_nx;

  logic [NUM_CLIENTS-1:0] rdy;
  logic [GW-1:0]          win;
  logic                   win_ok;
  int unsigned            idx;
  logic [DATA_W-1:0]      dvd_sel, dvs_sel;
  logic [MID_W-1:0]       mid;
  logic                   rsp_seen;

  // Search starts just after the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!win_ok && bus.cl_req_valid[GW'(idx)]) begin
        win    = GW'(idx);
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (rst_sync_l && state == S_IDLE && !bus.div_busy && win_ok) rdy[win] = 1'b1;
  end

  assign dvd_sel  = DATA_W'(bus.cl_dividend >> (32'(win) * DATA_W));
  assign dvs_sel  = DATA_W'(bus.cl_divisor >> (32'(win) * DATA_W));
  assign mid      = MID_W'(grant) + MID_W'(1);
  assign rsp_seen = bus.div_rsp_mid != MID_IDLE;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant;
    dvd_nx   = dvd;
    dvs_nx   = dvs;
    quot_nx  = quot;
    rem_nx   = rem;
    err_nx   = err;
    cnt_nx   = cnt;
    mm_nx    = mm;
    to_nx    = to;
    case (state)
      S_IDLE: begin
        if (rsp_seen) mm_nx = 1'b1;
        if (|rdy) begin
          grant_nx = win;
          ptr_nx   = win;
          dvd_nx   = dvd_sel;
          dvs_nx   = dvs_sel;
          if (dvs_sel == '0) begin
            quot_nx  = '1;
            rem_nx   = dvd_sel;
            err_nx   = 1'b1;
            state_nx = S_RSP;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (rsp_seen) mm_nx = 1'b1;
        cnt_nx   = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_seen) begin
          {quot_nx, rem_nx} = bus.div_rsp_data;
          err_nx   = 1'b0;
          if (bus.div_rsp_mid != mid) mm_nx = 1'b1;
          state_nx = S_RSP;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          quot_nx  = '0;
          rem_nx   = '0;
          err_nx   = 1'b1;
          to_nx    = 1'b1;
          state_nx = S_RSP;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_RSP: begin
        if (rsp_seen) mm_nx = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      state <= S_IDLE;
      ptr   <= GW'(NUM_CLIENTS - 1);
      grant <= '0;
      dvd   <= '0;
      dvs   <= '0;
      quot  <= '0;
      rem   <= '0;
      err   <= 1'b0;
      cnt   <= '0;
      mm    <= 1'b0;
      to    <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      grant <= grant_nx;
      dvd   <= dvd_nx;
      dvs   <= dvs_nx;
      quot  <= quot_nx;
      rem   <= rem_nx;
      err   <= err_nx;
      cnt   <= cnt_nx;
      mm    <= mm_nx;
      to    <= to_nx;
    end
  end

  assign bus.cl_req_rdy       = rdy;
  assign bus.cl_rsp_valid     = (state == S_RSP) ? (NUM_CLIENTS'(1) << grant) : '0;
  assign bus.cl_rsp_quot      = (state == S_RSP) ? quot : '0;
  assign bus.cl_rsp_rem       = (state == S_RSP) ? rem : '0;
  assign bus.cl_rsp_err       = (state == S_RSP) ? err : 1'b0;
  assign bus.div_req_mid      = (state == S_ISSUE) ? mid : MID_IDLE;
  assign bus.div_req_data     = (state == S_ISSUE) ? {dvd, dvs} : '0;
  assign bus.err_mid_mismatch = mm;
  assign bus.err_timeout      = to;
endmodule

// File: tb/tb_syn_gpu_div_arb.sv
// Bench for syn_gpu_div_arb: transaction-timestamp reference model compared every cycle,
// a behavioural divider, directed scenarios with literal expectations, then random traffic.
module tb_syn_gpu_div_arb;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int TO = 63;
  typedef logic [$clog2(N)-1:0] cid_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  syn_gpu_div_arb_if #(.NUM_CLIENTS(N), .DATA_W(DW), .MID_W(MW)) bus ();

  syn_gpu_div_arb #(.NUM_CLIENTS(N), .DATA_W(DW), .MID_W(MW), .TIMEOUT_CYC(TO)) dut (
    .clk_ir(clk), .rst_sync_l(rst_n), .bus(bus)
  );

  logic [N-1:0]  vld;
  logic          dbusy;
  logic [DW-1:0] dvd_a [N];
  logic [DW-1:0] dvs_a [N];
  assign bus.cl_req_valid = vld;
  assign bus.div_busy     = dbusy;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.cl_dividend[g*DW +: DW] = dvd_a[g];
    assign bus.cl_divisor[g*DW +: DW]  = dvs_a[g];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_note(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Divider: answers L=div_lat cycles after seeing a request; mode 1 never answers, mode 2 answers MID 3.
  int div_lat = 2;
  int div_mode = 0;
  initial begin : divider
    logic [MW-1:0] m;
    logic [DW-1:0] a, b;
    bit abort;
    bus.div_rsp_mid  = '0;
    bus.div_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.div_req_mid != '0 && div_mode != 1) begin
        m = (div_mode == 2) ? MW'(3) : bus.div_req_mid;
        a = bus.div_req_data[2*DW-1:DW];
        b = bus.div_req_data[DW-1:0];
        abort = 1'b0;
        for (int i = 0; i < div_lat; i++) begin
          @(posedge clk);
          if (rst_n !== 1'b1) abort = 1'b1;
        end
        if (!abort) begin
          #1;
          bus.div_rsp_mid  = m;
          bus.div_rsp_data = {a / b, a % b};
          @(posedge clk);
          #1;
          bus.div_rsp_mid  = '0;
          bus.div_rsp_data = 32'($urandom);
        end
      end
    end
  end

  // Reference model: one transaction record with the cycle numbers at which things must happen.
  int            cyc = 0;
  bit            m_busy, m_div0, m_e, m_mm, m_to;
  cid_t          m_client, m_ptr;
  int            m_issue, m_rsp;
  logic [DW-1:0] m_a, m_b, m_q, m_r;
  int            rsp_count = 0;
  logic [MW-1:0]     mid_log [$];
  logic [2*DW-1:0]   data_log [$];

  always @(negedge clk) begin : compare
    logic [N-1:0]    e_rdy, e_rv;
    logic [MW-1:0]   e_mid;
    logic [2*DW-1:0] e_data;
    logic [DW-1:0]   e_q, e_r;
    logic            e_e;
    cid_t            w, idx;
    bit              w_ok, in_wait;
    cyc++;
    e_rdy = '0; e_rv = '0; e_mid = '0; e_data = '0; e_q = '0; e_r = '0; e_e = 1'b0;
    w = '0; w_ok = 1'b0;
    if (rst_n !== 1'b1) begin
      m_busy = 1'b0; m_ptr = cid_t'(N - 1); m_mm = 1'b0; m_to = 1'b0;
    end else begin
      if (m_busy && m_rsp == cyc) begin
        e_rv = N'(1) << m_client; e_q = m_q; e_r = m_r; e_e = m_e;
      end
      if (m_busy && !m_div0 && cyc == m_issue) begin
        e_mid = MW'(int'(m_client) + 1); e_data = {m_a, m_b};
      end
      if (!m_busy && !dbusy) begin
        for (int k = 1; k <= N; k++) begin
          idx = cid_t'((int'(m_ptr) + k) % N);
          if (!w_ok && vld[idx]) begin w = idx; w_ok = 1'b1; end
        end
        if (w_ok) e_rdy = N'(1) << w;
      end
    end
    chk("req_rdy",   64'(bus.cl_req_rdy),   64'(e_rdy));
    chk("rsp_valid", 64'(bus.cl_rsp_valid), 64'(e_rv));
    chk("rsp_quot",  64'(bus.cl_rsp_quot),  64'(e_q));
    chk("rsp_rem",   64'(bus.cl_rsp_rem),   64'(e_r));
    chk("rsp_err",   64'(bus.cl_rsp_err),   64'(e_e));
    chk("req_mid",   64'(bus.div_req_mid),  64'(e_mid));
    chk("req_data",  64'(bus.div_req_data), 64'(e_data));
    chk("err_mm",    64'(bus.err_mid_mismatch), 64'(m_mm));
    chk("err_to",    64'(bus.err_timeout),  64'(m_to));
    if (bus.div_req_mid != '0) begin
      mid_log.push_back(bus.div_req_mid);
      data_log.push_back(bus.div_req_data);
    end
    if (bus.cl_rsp_valid != '0) rsp_count++;
    if (rst_n === 1'b1) begin
      in_wait = m_busy && !m_div0 && cyc > m_issue && m_rsp < 0;
      if (bus.div_rsp_mid != '0 && !in_wait) m_mm = 1'b1;
      if (m_busy && m_rsp == cyc) begin
        m_busy = 1'b0;
      end else if (in_wait) begin
        if (bus.div_rsp_mid != '0) begin
          m_rsp = cyc + 1; {m_q, m_r} = bus.div_rsp_data; m_e = 1'b0;
          if (int'(bus.div_rsp_mid) != int'(m_client) + 1) m_mm = 1'b1;
        end else if (cyc - m_issue == TO) begin
          m_rsp = cyc + 1; m_q = '0; m_r = '0; m_e = 1'b1; m_to = 1'b1;
        end
      end else if (!m_busy && w_ok) begin
        m_busy = 1'b1; m_client = w; m_ptr = w; m_a = dvd_a[w]; m_b = dvs_a[w];
        if (m_b == '0) begin
          m_div0 = 1'b1; m_rsp = cyc + 1; m_q = '1; m_r = m_a; m_e = 1'b1;
        end else begin
          m_div0 = 1'b0; m_issue = cyc + 1; m_rsp = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = '0; dbusy = 1'b0; div_lat = 2; div_mode = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_req(input cid_t c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit got;
    got = 1'b0;
    dvd_a[c] = a; dvs_a[c] = b; vld[c] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.cl_req_rdy[c]) got = 1'b1;
    end
    if (!got) fail_note("req_accept");
    tick();
    vld[c] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      n++;
      if (bus.cl_rsp_valid != '0) got = 1'b1;
    end
    if (!got) fail_note("rsp_wait");
  endtask

  initial begin : main
    int n, start;
    rst_n = 1'b1; vld = '0; dbusy = 1'b0;
    for (int i = 0; i < N; i++) begin dvd_a[i] = '0; dvs_a[i] = 16'd1; end
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid", 64'(bus.div_req_mid), 64'(0));
    chk("reset_rsp", 64'(bus.cl_rsp_valid), 64'(0));
    do_reset();

    // 100/7 from client 0
    mid_log.delete(); data_log.delete();
    do_req(0, 16'd100, 16'd7);
    wait_rsp(n);
    chk("t1_lat",   64'(n), 64'(4));
    chk("t1_valid", 64'(bus.cl_rsp_valid), 64'(4'b0001));
    chk("t1_quot",  64'(bus.cl_rsp_quot), 64'(14));
    chk("t1_rem",   64'(bus.cl_rsp_rem), 64'(2));
    chk("t1_err",   64'(bus.cl_rsp_err), 64'(0));
    chk("t1_nmid",  64'(mid_log.size()), 64'(1));
    chk("t1_mid",   64'(mid_log[0]), 64'(1));
    chk("t1_data",  64'(data_log[0]), 64'({16'd100, 16'd7}));
    repeat (4) tick();

    // all clients hold valid: grants rotate 0,1,2,3,0
    do_reset();
    mid_log.delete();
    for (int i = 0; i < N; i++) begin dvd_a[i] = DW'(1000 + i); dvs_a[i] = DW'(i + 3); end
    start = rsp_count;
    vld = '1;
    for (int i = 0; i < 300 && rsp_count < start + 5; i++) @(negedge clk);
    if (rsp_count < start + 5) fail_note("rr_wait");
    tick();
    vld = '0;
    for (int i = 0; i < 5; i++) chk($sformatf("rr_mid%0d", i), 64'(mid_log[i]), 64'(i % 4 + 1));
    repeat (10) tick();

    // divide by zero on client 2
    mid_log.delete();
    do_req(2, 16'd55, 16'd0);
    @(negedge clk);
    chk("dz_valid", 64'(bus.cl_rsp_valid), 64'(4'b0100));
    chk("dz_quot",  64'(bus.cl_rsp_quot), 64'(16'hFFFF));
    chk("dz_rem",   64'(bus.cl_rsp_rem), 64'(55));
    chk("dz_err",   64'(bus.cl_rsp_err), 64'(1));
    chk("dz_nomid", 64'(mid_log.size()), 64'(0));
    repeat (3) tick();

    // silent divider: timeout, then a normal request
    div_mode = 1;
    do_req(1, 16'd9, 16'd3);
    wait_rsp(n);
    chk("to_lat",    64'(n), 64'(65));
    chk("to_valid",  64'(bus.cl_rsp_valid), 64'(4'b0010));
    chk("to_err",    64'(bus.cl_rsp_err), 64'(1));
    chk("to_quot",   64'(bus.cl_rsp_quot), 64'(0));
    tick();
    chk("to_sticky", 64'(bus.err_timeout), 64'(1));
    div_mode = 0;
    repeat (2) tick();
    do_req(3, 16'd200, 16'd9);
    wait_rsp(n);
    chk("post_to_valid", 64'(bus.cl_rsp_valid), 64'(4'b1000));
    chk("post_to_quot",  64'(bus.cl_rsp_quot), 64'(22));
    chk("post_to_rem",   64'(bus.cl_rsp_rem), 64'(2));
    chk("post_to_err",   64'(bus.cl_rsp_err), 64'(0));
    repeat (3) tick();

    // wrong response MID still delivered to the owner
    div_mode = 2;
    do_req(0, 16'd50, 16'd6);
    wait_rsp(n);
    chk("mm_valid", 64'(bus.cl_rsp_valid), 64'(4'b0001));
    chk("mm_quot",  64'(bus.cl_rsp_quot), 64'(8));
    chk("mm_rem",   64'(bus.cl_rsp_rem), 64'(2));
    tick();
    chk("mm_sticky", 64'(bus.err_mid_mismatch), 64'(1));
    div_mode = 0;
    repeat (3) tick();
    dbusy = 1'b1; vld = '1;
    repeat (4) begin
      @(negedge clk);
      chk("busy_rdy", 64'(bus.cl_req_rdy), 64'(0));
    end
    tick();
    vld = '0; dbusy = 1'b0;
    repeat (3) tick();

    // randomized traffic
    do_reset();
    for (int t = 0; t < 2500; t++) begin
      vld = N'($urandom);
      for (int i = 0; i < N; i++) begin
        dvd_a[i] = DW'($urandom);
        dvs_a[i] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 65535));
      end
      dbusy    = ($urandom_range(0, 3) == 0);
      div_lat  = $urandom_range(1, 6);
      div_mode = ($urandom_range(0, 15) == 0) ? 2 : 0;
      tick();
    end
    vld = '0; div_mode = 0;
    repeat (12) tick();

    // reset in the middle of a wait
    do_reset();
    div_lat = 20;
    do_req(0, 16'd77, 16'd5);
    repeat (3) tick();
    vld = '1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rdy",   64'(bus.cl_req_rdy), 64'(0));
    chk("rst_rsp",   64'(bus.cl_rsp_valid), 64'(0));
    chk("rst_mid",   64'(bus.div_req_mid), 64'(0));
    chk("rst_errs",  64'({bus.err_mid_mismatch, bus.err_timeout}), 64'(0));
    tick();
    div_lat = 2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first", 64'(bus.cl_req_rdy), 64'(4'b0001));
    tick();
    vld = '0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/syn_gpu_div_arb.md
Name: syn_gpu_div_arb

Overview:
- Round-robin arbiter and request sequencer that sits directly upstream of the GPU divider on the mulberry bus.
- Shares the single divider among NUM_CLIENTS GPU agents (e.g. line and fill engines).
- Keeps at most one division outstanding, issues single-cycle MID-tagged requests, and routes each response back to its requester.
- Short-circuits divide-by-zero and recovers from a lost response via timeout.

Parameters:
NUM_CLIENTS, 4, number of requesting agents (2..7)
DATA_W, 16, dividend/divisor/quotient/remainder width
MID_W, 4, mulberry MID width; MID_IDLE = 0
TIMEOUT_CYC, 63, max cycles waiting for a divider response

Ports:
clk_ir  in  1  clock
rst_sync_l  in  1  asynchronous active-low reset
cl_req_valid  in  NUM_CLIENTS  per-client request valid
cl_req_rdy  out  NUM_CLIENTS  per-client accept; a transfer occurs when valid&rdy
cl_dividend  in  NUM_CLIENTS*DATA_W  packed dividends, client i at [i*DATA_W+:DATA_W]
cl_divisor  in  NUM_CLIENTS*DATA_W  packed divisors
cl_rsp_valid  out  NUM_CLIENTS  one-cycle response pulse to the owning client
cl_rsp_quot  out  DATA_W  quotient, shared, valid with cl_rsp_valid
cl_rsp_rem  out  DATA_W  remainder, shared
cl_rsp_err  out  1  response is div-by-zero or timeout
div_req_mid  out  MID_W  request MID to divider, MID_IDLE when no request
div_req_data  out  2*DATA_W  {dividend, divisor}
div_busy  in  1  divider busy
div_rsp_mid  in  MID_W  divider response MID, non-idle for one cycle
div_rsp_data  in  2*DATA_W  {quotient, remainder}
err_mid_mismatch  out  1  sticky: response MID differs from the outstanding MID
err_timeout  out  1  sticky: timeout occurred

Behaviour:
- Reset values:
  - All outputs 0; div_req_mid = MID_IDLE.
  - FSM in IDLE.
  - RR pointer = NUM_CLIENTS-1, so client 0 wins first.
  - Timeout counter 0.
- Client i uses MID = i+1. MID_IDLE is never issued.
- FSM states: IDLE, ISSUE, WAIT, RSP.
- IDLE:
  - cl_req_rdy is one-hot to the RR winner among cl_req_valid, only when div_busy=0. Otherwise all zero.
  - Search order starts at pointer+1, wrapping.
  - On transfer: latch operands and grant index, pointer := winner.
  - Divisor == 0 → RSP with quot = all ones, rem = dividend, err = 1. The divider is not used.
  - Otherwise → ISSUE.
- ISSUE (exactly 1 cycle):
  - div_req_mid = MID, div_req_data = {dividend, divisor}.
  - → WAIT. Clear the counter.
- WAIT:
  - div_req_mid = MID_IDLE. The counter increments each cycle.
  - On div_rsp_mid != MID_IDLE: capture div_rsp_data → RSP.
  - If div_rsp_mid != the issued MID, set err_mid_mismatch. The data is still delivered to the granted client.
  - Counter reaching TIMEOUT_CYC without a response: set err_timeout → RSP with quot = rem = 0, err = 1.
- RSP (exactly 1 cycle):
  - cl_rsp_valid[grant] = 1; quot, rem and err are driven. All response outputs are 0 outside RSP.
  - → IDLE.
- cl_req_rdy is 0 in every state except IDLE. Only one request is ever outstanding.
- Latency: accept at cycle T, div_req_mid at T+1. Response pulse at T+L+2, where L = cycles from div_req_mid to div_rsp_mid. Div-by-zero response at T+1.
- A response MID arriving in IDLE, ISSUE or RSP is ignored and sets err_mid_mismatch.
- Sticky errors clear only on reset.
- Reset mid-operation: immediate return to reset values. The outstanding request is abandoned.

Test Plan:
- Client 0 requests 100/7 → div_req_mid = 1 for exactly one cycle with data {16'd100, 16'd7}. Divider model returns MID 1 → cl_rsp_valid[0] pulse, quot = 14, rem = 2, err = 0.
- Clients 0..3 all hold valid continuously → grants 0,1,2,3,0 in order, never two outstanding, div_req_mid sequence 1,2,3,4,1.
- Client 2 requests 55/0 → no div_req_mid. cl_rsp_valid[2] one cycle after accept, quot = 16'hFFFF, rem = 55, err = 1.
- Divider never responds → after 63 WAIT cycles cl_rsp_valid pulses with err = 1 and err_timeout stays 1. The next request proceeds normally.
- Divider returns MID 3 for an outstanding MID 1 → err_mid_mismatch = 1 and data delivered to client 0. Separately, div_busy = 1 in IDLE → cl_req_rdy = 0.
- Assert reset during WAIT → all outputs 0 and div_req_mid = MID_IDLE immediately. After release, client 0 wins first.
